// File: rtl/pulse_capture_pkg.sv
// Shared types and default sizes for the pulse_capture input-capture block.
package pulse_capture_pkg;

   localparam int unsigned CNT_W_DEF       = 16;
   localparam int unsigned SYNC_STAGES_DEF = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      MEASURE = 2'd2
   } state_e;

endpackage

// File: rtl/pulse_capture_edge_sync.sv
// Synchronizes the asynchronous pulse line and emits a one-cycle rise strobe.
// Optional stability filter enabled by PULSE_CAPTURE_GLITCH_FILTER_EN.
module pulse_capture_edge_sync
   import pulse_capture_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic pulse_in,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_lvl;

   always_ff @(posedge clk) begin
      if (!reset) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
   end

   assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef PULSE_CAPTURE_GLITCH_FILTER_EN
   logic [1:0] hist_q;
   logic       filt_q;

   // Level is accepted only after three matching samples; rise fires as it flips high.
   always_ff @(posedge clk) begin
      if (!reset) begin
         hist_q <= '0;
         filt_q <= 1'b0;
         rise   <= 1'b0;
      end else begin
         hist_q <= {hist_q[0], sync_lvl};
         if ((sync_lvl == hist_q[0]) && (sync_lvl == hist_q[1])) filt_q <= sync_lvl;
         rise <= ~filt_q & sync_lvl & hist_q[0] & hist_q[1];
      end
   end
`else
   logic prev_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         prev_q <= 1'b0;
         rise   <= 1'b0;
      end else begin
         prev_q <= sync_lvl;
         rise   <= sync_lvl & ~prev_q;
      end
   end
`endif

endmodule

// File: rtl/pulse_capture.sv
// Input-capture peripheral: measures clk cycles between rising edges of pulse_in.
// Build option PULSE_CAPTURE_GLITCH_FILTER_EN adds a glitch filter in the edge path.
module pulse_capture
   import pulse_capture_pkg::*;
#(
   parameter int unsigned CNT_W       = CNT_W_DEF,
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             pulse_in,
   output logic [CNT_W-1:0] period,
   output logic             valid,
   input  logic             ack,
   output logic             ovf,
   output logic             overrun,
   input  logic             clr_overrun
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rise;
   logic             sat_c;
   logic             cap_c;
   logic             cap_ovf_c;

   pulse_capture_edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_edge_sync (
      .clk      (clk),
      .reset    (reset),
      .pulse_in (pulse_in),
      .rise     (rise)
   );

   assign sat_c = (cnt_q == CNT_MAX);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (enable) state_d = ARMED;
         ARMED:   if (!enable) state_d = IDLE;
                  else if (rise) state_d = MEASURE;
         MEASURE: if (!enable) state_d = IDLE;
                  else if (!rise && sat_c) state_d = ARMED;
         default: state_d = IDLE;
      endcase
   end

   // Counter restarts at 1 on every edge so back-to-back periods need no gap.
   always_comb begin
      cnt_d     = '0;
      cap_c     = 1'b0;
      cap_ovf_c = 1'b0;
      case (state_q)
         ARMED: begin
            if (enable && rise) cnt_d = CNT_W'(1);
         end
         MEASURE: begin
            if (enable) begin
               if (rise) begin
                  cap_c = 1'b1;
                  cnt_d = CNT_W'(1);
               end else if (sat_c) begin
                  cap_c     = 1'b1;
                  cap_ovf_c = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: ;
      endcase
   end

   // A capture with ack pending in the same cycle still loads; otherwise it is dropped.
   always_ff @(posedge clk) begin
      if (!reset) begin
         period  <= '0;
         valid   <= 1'b0;
         ovf     <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (cap_c && (!valid || ack)) begin
            period <= cnt_q;
            ovf    <= cap_ovf_c;
            valid  <= 1'b1;
         end else if (valid && ack) begin
            valid <= 1'b0;
         end
         if (cap_c && valid && !ack) overrun <= 1'b1;
         else if (clr_overrun)       overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pulse_capture.sv
// Self-checking bench for pulse_capture: directed scenarios plus randomized pulse trains
// compared each cycle against an edge-time reference model.
module tb_pulse_capture;
   import pulse_capture_pkg::*;

   localparam int unsigned CW  = 8;
   localparam int unsigned SS  = 2;
   localparam int unsigned SAT = (1 << CW) - 1;
`ifdef PULSE_CAPTURE_GLITCH_FILTER_EN
   localparam int unsigned LAT   = SS + 3;
   localparam int unsigned MIN_W = 3;
   localparam int unsigned P_A   = 6;
   localparam int unsigned P_B   = 6;
`else
   localparam int unsigned LAT   = SS + 1;
   localparam int unsigned MIN_W = 1;
   localparam int unsigned P_A   = 5;
   localparam int unsigned P_B   = 4;
`endif

   localparam int M_IDLE  = 0;
   localparam int M_ARMED = 1;
   localparam int M_MEAS  = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          enable = 1'b0;
   logic          pulse_in = 1'b0;
   logic [CW-1:0] period;
   logic          valid;
   logic          ack = 1'b0;
   logic          ovf;
   logic          overrun;
   logic          clr_overrun = 1'b0;

   pulse_capture #(
      .CNT_W       (CW),
      .SYNC_STAGES (SS)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .pulse_in    (pulse_in),
      .period      (period),
      .valid       (valid),
      .ack         (ack),
      .ovf         (ovf),
      .overrun     (overrun),
      .clr_overrun (clr_overrun)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned cyc      = 0;
   bit          rand_ack = 1'b0;

   // Reference model: periods are differences of edge arrival times.
   int unsigned q_cap[$];
   int          m_st = M_IDLE;
   int unsigned m_last = 0;
   int unsigned m_period = 0;
   bit          m_valid = 1'b0;
   bit          m_ovf = 1'b0;
   bit          m_ovr = 1'b0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic model_edge();
      bit          rise_now;
      bit          cap;
      bit          cap_ovf;
      bit          drop;
      int unsigned cap_val;
      rise_now = 1'b0;
      cap      = 1'b0;
      cap_ovf  = 1'b0;
      cap_val  = 0;
      if (q_cap.size() > 0 && q_cap[0] == cyc) begin
         rise_now = 1'b1;
         void'(q_cap.pop_front());
      end
      if (!reset) begin
         m_st = M_IDLE; m_period = 0; m_valid = 1'b0; m_ovf = 1'b0; m_ovr = 1'b0;
         q_cap.delete();
         return;
      end
      case (m_st)
         M_IDLE: if (enable) m_st = M_ARMED;
         M_ARMED: begin
            if (!enable) m_st = M_IDLE;
            else if (rise_now) begin m_st = M_MEAS; m_last = cyc; end
         end
         default: begin
            if (!enable) m_st = M_IDLE;
            else if (rise_now) begin cap = 1'b1; cap_val = cyc - m_last; m_last = cyc; end
            else if (cyc - m_last == SAT) begin
               cap = 1'b1; cap_val = SAT; cap_ovf = 1'b1; m_st = M_ARMED;
            end
         end
      endcase
      drop = cap && m_valid && !ack;
      if (cap && !drop) begin
         m_period = cap_val; m_ovf = cap_ovf; m_valid = 1'b1;
      end else if (!cap && m_valid && ack) begin
         m_valid = 1'b0;
      end
      if (drop) m_ovr = 1'b1;
      else if (clr_overrun) m_ovr = 1'b0;
   endtask

   task automatic step();
      if (rand_ack) begin
         ack         = ($urandom_range(3) == 0);
         clr_overrun = ($urandom_range(15) == 0);
      end
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      check("period", 32'(period), m_period);
      check("valid", 32'(valid), 32'(m_valid));
      check("ovf", 32'(ovf), 32'(m_ovf));
      check("overrun", 32'(overrun), 32'(m_ovr));
   endtask

   task automatic pulse(input int unsigned width, input int unsigned gap, input int ack_at);
      if (width >= MIN_W) q_cap.push_back(cyc + 1 + LAT);
      for (int unsigned i = 0; i < gap; i++) begin
         pulse_in = (i < width);
         if (ack_at >= 0) ack = (int'(i) == ack_at);
         step();
      end
      if (ack_at >= 0) ack = 1'b0;
   endtask

   task automatic idle(input int unsigned n);
      pulse_in = 1'b0;
      repeat (n) step();
   endtask

   task automatic ack_once();
      ack = 1'b1;
      step();
      ack = 1'b0;
   endtask

   task automatic rearm();
      enable = 1'b0;
      idle(LAT + 2);
      enable = 1'b1;
      idle(2);
   endtask

   initial begin
      // Reset state
      idle(3);
      check("rst_period", 32'(period), 0);
      check("rst_valid", 32'(valid), 0);
      reset  = 1'b1;
      enable = 1'b1;
      idle(3);

      // Periods of 10, acked continuously
      ack = 1'b1;
      repeat (4) pulse(3, 10, -1);
      idle(LAT + 3);
      ack = 1'b0;
      check("t1_period", 32'(period), 10);
      check("t1_ovf", 32'(ovf), 0);
      check("t1_overrun", 32'(overrun), 0);

      // Single edge then saturation
      rearm();
      pulse(3, SAT + LAT + 6, -1);
      check("sat_period", 32'(period), SAT);
      check("sat_ovf", 32'(ovf), 1);
      check("sat_valid", 32'(valid), 1);
      ack_once();
      check("sat_ack_valid", 32'(valid), 0);
      check("sat_hold_ovf", 32'(ovf), 1);

      // Re-arm edge gives no result; then 6 and 7 unacked -> overrun
      pulse(3, 6, -1);
      check("rearm_no_result", 32'(valid), 0);
      pulse(3, 7, -1);
      pulse(3, 20, -1);
      check("ovr_period", 32'(period), 6);
      check("ovr_flag", 32'(overrun), 1);
      check("ovr_valid", 32'(valid), 1);
      ack_once();
      clr_overrun = 1'b1;
      step();
      clr_overrun = 1'b0;
      check("clr_valid", 32'(valid), 0);
      check("clr_overrun", 32'(overrun), 0);

      // Ack in the exact cycle of the second capture
      rearm();
      pulse(3, P_A, -1);
      pulse(3, P_A, -1);
      pulse(3, 20, int'(LAT));
      check("same_ack_period", 32'(period), P_A);
      check("same_ack_valid", 32'(valid), 1);
      check("same_ack_overrun", 32'(overrun), 0);

      // Enable drop mid-measure
      ack_once();
      enable = 1'b0;
      idle(3);
      enable = 1'b1;
      idle(2);
      pulse(3, P_B, -1);
      check("en_no_spurious", 32'(valid), 0);
      pulse(3, 20, -1);
      check("en_period", 32'(period), P_B);
      check("en_valid", 32'(valid), 1);

      // Reset mid-measure with valid held
      reset = 1'b0;
      step();
      check("mid_rst_period", 32'(period), 0);
      check("mid_rst_valid", 32'(valid), 0);
      check("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
      reset = 1'b1;
      idle(3);

      // Short glitch while measuring
      pulse(3, 8, -1);
      pulse(1, 8, -1);
`ifdef PULSE_CAPTURE_GLITCH_FILTER_EN
      check("glitch_ignored", 32'(valid), 0);
`else
      check("glitch_period", 32'(period), 8);
`endif

      // Randomized pulse trains with random ack / clear
      rearm();
      rand_ack = 1'b1;
      for (int k = 0; k < 40; k++) pulse(3, $urandom_range(40, 6), -1);
      rand_ack    = 1'b0;
      ack         = 1'b0;
      clr_overrun = 1'b0;
      idle(LAT + 5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pulse_capture.md
Name: pulse_capture

Overview:
- Input-capture peripheral: measures the period, in clk cycles, between consecutive rising edges of an external pulse line.
- Typical sources: an off-chip signal or the output of a sibling timer.
- Sits on the CPU I/O bus next to the timer and presents each measurement through a valid/ack handshake.
- Flags counter saturation (no edge seen) and overrun (a measurement lost because the CPU had not acked).

Parameters:
- CNT_W, 16, width of period counter and period output.
- SYNC_STAGES, 2, flip-flops in the input synchronizer (minimum 2).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous reset, active-low (0 = reset).
- enable  in  1  1 = capture running; 0 = idle, counter cleared.
- pulse_in  in  1  asynchronous external pulse line.
- period  out  CNT_W  last captured period in clk cycles.
- valid  out  1  period/ovf hold an unacknowledged measurement.
- ack  in  1  CPU consumed the measurement; sampled only while valid=1.
- ovf  out  1  the current measurement is a saturation (no second edge before counter max).
- overrun  out  1  sticky: a measurement was dropped while valid=1.
- clr_overrun  in  1  clears overrun.

Behaviour:
- Reset (reset=0 at posedge), all outputs and state cleared:
  - period=0, valid=0, ovf=0, overrun=0.
  - Synchronizer flops=0, counter=0, state=IDLE.
  - Reset during any state aborts the measurement with no output.
- Edge detection:
  - pulse_in passes through SYNC_STAGES flops, then a one-cycle rising-edge detect (sync=1, previous=0).
  - Detection latency is SYNC_STAGES+1 cycles. It is constant, so it does not affect period values.
- States:
  - IDLE: entered when enable=0. Counter held at 0.
  - IDLE -> ARMED when enable=1.
  - ARMED: waits for the first detected edge. On that edge, cnt<=1 and go to MEASURE.
  - MEASURE: cnt increments by 1 each cycle.
- Capture in MEASURE:
  - On a detected edge, capture cnt and set cnt<=1; stay in MEASURE, so back-to-back periods have no gap.
  - Captured value = number of clk cycles between the two detected edges. Edges 10 cycles apart give period=10.
  - Minimum observable period is 2.
- Saturation:
  - In MEASURE, if cnt reaches 2^CNT_W-1 with no edge, capture period=all-ones with ovf=1, then go to ARMED.
  - Counter never wraps.
- Capture-to-output:
  - Each capture loads period/ovf and sets valid=1 on the following posedge.
  - valid stays 1 until ack=1 is sampled with valid=1, and clears on the next edge.
  - period/ovf hold their values after ack.
- Capture while valid=1 and no ack the same cycle:
  - The new result is dropped; period/ovf are unchanged and overrun<=1.
- Capture and ack in the same cycle: the new result loads, valid stays 1, and overrun is not set.
- enable falling in any state:
  - Go to IDLE next cycle and clear cnt.
  - A measurement in progress is discarded; valid, period and overrun are kept.
- clr_overrun: clears overrun next cycle. If an overrun event occurs in the same cycle, set wins.
- Arithmetic: cnt is an unsigned CNT_W-bit value; comparisons are against the all-ones constant only.

Optional Feature:
- Macro: PULSE_CAPTURE_GLITCH_FILTER_EN.
- Defined: a 2-cycle stability filter sits after the synchronizer. The filtered level changes only when the synchronized input has held its new value for 3 consecutive cycles. Pulses of 2 cycles or fewer are ignored. Detection latency becomes SYNC_STAGES+3.
- Undefined: no filter; latency is SYNC_STAGES+1.
- Measured periods between clean edges are identical in both builds.

Decomposition:
- Package pulse_capture_pkg holds:
  - State enum (IDLE, ARMED, MEASURE).
  - Default CNT_W and SYNC_STAGES constants.
- Sub-module edge_sync contains:
  - Synchronizer chain.
  - Optional glitch filter.
  - Rising-edge detector with single-cycle output rise.
- pulse_capture contains the FSM, counter and handshake.

Test Plan:
- Reset and enable, then rising edges 10 cycles apart x3, ack each result -> three results of period=10, ovf=0, overrun=0.
- Single edge, then no more edges with CNT_W=8 -> after 255 cycles period=255, ovf=1, valid=1; the next edge re-arms with no new result.
- Periods of 6 then 7 with no ack -> period=6 is retained and overrun=1. Ack then clr_overrun -> valid=0, overrun=0.
- ack asserted in the exact cycle of the second capture (periods 5,5) -> period=5, valid stays 1, overrun=0.
- enable=0 mid-MEASURE, then re-enable with edges 4 apart -> no spurious result; the first result after the re-arm edge is period=4.
- reset=0 asserted mid-MEASURE with valid=1 -> next cycle all outputs are 0 and the state is IDLE. With the filter enabled, a 1-cycle glitch on pulse_in produces no capture.
